link_power_sequencer: RTL and testbench

Sequences power delivery onto the two TIA-568B pair groups (1236 and 5478) of the power-over-link path. The split-radio/PostLNA sensing chain is a single shared probe, so the block arbitrates it between the two groups. Each group is ramped only after a good probe result, then supervised continuously while powered. Its outputs gate the MakeVoltPN supplies for each pair group.

---
 rtl/link_power_sequencer.sv | 178 +++++++++++++++++
 tb/tb_link_power_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_power_sequencer.sv
// rtl/link_power_sequencer.sv - Two-group link power sequencer with a shared, round-robin probe arbiter.
module link_power_sequencer #(
  parameter int DETECT_CYCLES   = 200,
  parameter int RAMP_CYCLES     = 1000,
  parameter int COOLDOWN_CYCLES = 5000,
  parameter int CNT_W           = 16
) (
  input  logic       Clock100Mhz,
  input  logic       ResetN,
  input  logic [1:0] Enable,
  output logic       ProbeStart,
  output logic       ProbeSel,
  input  logic       ProbeDone,
  input  logic       ProbeGood,
  input  logic [1:0] PairOk,
  input  logic [1:0] Overload,
  output logic [1:0] PowerOn,
  output logic [2:0] State1236,
  output logic [2:0] State5478,
  output logic [1:0] FaultSticky,
  input  logic       FaultClear
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_PROBE = 3'd1,
    ST_PROBING    = 3'd2,
    ST_RAMP       = 3'd3,
    ST_ON         = 3'd4,
    ST_COOLDOWN   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DETECT_LAST = CNT_W'(DETECT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(RAMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);

  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       pair_low_q, pair_low_d;
  logic [1:0]       fault_q, fault_d;
  logic [1:0]       power_on_q, power_on_d;
  logic             busy_q, busy_d;
  logic             sel_q, sel_d;
  logic             ptr_q, ptr_d;
  logic             probe_start_q, probe_start_d;
  logic [CNT_W-1:0] arb_cnt_q, arb_cnt_d;

  logic [1:0] req;
  logic [1:0] done_mine;
  logic [1:0] fault_evt;
  logic       grant_valid;
  logic       grant_sel;
  logic       arb_timeout;
  logic       probe_fin;

  // The arbiter keeps its own timeout so an abandoned probe still frees on time.
  always_comb begin
    req = 2'b00;
    for (int g = 0; g < 2; g++) begin
      req[g] = (state_q[g] == ST_WAIT_PROBE);
    end
    grant_valid   = !busy_q && (req != 2'b00);
    grant_sel     = (req == 2'b11) ? ptr_q : req[1];
    arb_timeout   = busy_q && (arb_cnt_q == DETECT_LAST);
    probe_fin     = busy_q && (ProbeDone || arb_timeout);
    done_mine[0]  = ProbeDone && busy_q && !sel_q;
    done_mine[1]  = ProbeDone && busy_q && sel_q;
    busy_d        = grant_valid || (busy_q && !probe_fin);
    sel_d         = grant_valid ? grant_sel : sel_q;
    ptr_d         = grant_valid ? ~grant_sel : ptr_q;
    probe_start_d = grant_valid;
    arb_cnt_d     = arb_cnt_q;
    if (grant_valid) begin
      arb_cnt_d = '0;
    end else if (busy_q && (arb_cnt_q != '1)) begin
      arb_cnt_d = arb_cnt_q + 1'b1;
    end
  end

  always_comb begin
    fault_evt = 2'b00;
    for (int g = 0; g < 2; g++) begin
      state_d[g] = state_q[g];
      case (state_q[g])
        ST_IDLE: begin
          if (Enable[g]) state_d[g] = ST_WAIT_PROBE;
        end
        ST_WAIT_PROBE: begin
          if (!Enable[g]) state_d[g] = ST_IDLE;
          else if (grant_valid && (grant_sel == 1'(g))) state_d[g] = ST_PROBING;
        end
        ST_PROBING: begin
          if (!Enable[g]) begin
            state_d[g] = ST_IDLE;
          end else if (done_mine[g]) begin
            state_d[g] = ProbeGood ? ST_RAMP : ST_WAIT_PROBE;
          end else if (cnt_q[g] == DETECT_LAST) begin
            fault_evt[g] = 1'b1;
            state_d[g]   = ST_COOLDOWN;
          end
        end
        ST_RAMP: begin
          if (!Enable[g]) begin
            state_d[g] = ST_IDLE;
          end else if (cnt_q[g] == RAMP_LAST) begin
            if (PairOk[g]) begin
              state_d[g] = ST_ON;
            end else begin
              fault_evt[g] = 1'b1;
              state_d[g]   = ST_COOLDOWN;
            end
          end
        end
        ST_ON: begin
          if (!Enable[g]) begin
            state_d[g] = ST_IDLE;
          end else if (Overload[g] || (!PairOk[g] && pair_low_q[g])) begin
            fault_evt[g] = 1'b1;
            state_d[g]   = ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          if (cnt_q[g] == COOL_LAST) state_d[g] = ST_IDLE;
        end
        default: state_d[g] = ST_IDLE;
      endcase

      if (state_d[g] != state_q[g]) cnt_d[g] = '0;
      else if (cnt_q[g] == '1)      cnt_d[g] = cnt_q[g];
      else                          cnt_d[g] = cnt_q[g] + 1'b1;

      pair_low_d[g] = (state_q[g] == ST_ON) && !PairOk[g];
      power_on_d[g] = (state_d[g] == ST_RAMP) || (state_d[g] == ST_ON);
      // A new fault overrides a simultaneous clear.
      fault_d[g]    = fault_evt[g] || (fault_q[g] && !FaultClear);
    end
  end

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      for (int g = 0; g < 2; g++) begin
        state_q[g] <= ST_IDLE;
        cnt_q[g]   <= '0;
      end
      pair_low_q    <= 2'b00;
      fault_q       <= 2'b00;
      power_on_q    <= 2'b00;
      busy_q        <= 1'b0;
      sel_q         <= 1'b0;
      ptr_q         <= 1'b0;
      probe_start_q <= 1'b0;
      arb_cnt_q     <= '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        state_q[g] <= state_d[g];
        cnt_q[g]   <= cnt_d[g];
      end
      pair_low_q    <= pair_low_d;
      fault_q       <= fault_d;
      power_on_q    <= power_on_d;
      busy_q        <= busy_d;
      sel_q         <= sel_d;
      ptr_q         <= ptr_d;
      probe_start_q <= probe_start_d;
      arb_cnt_q     <= arb_cnt_d;
    end
  end

  assign ProbeStart  = probe_start_q;
  assign ProbeSel    = sel_q;
  assign PowerOn     = power_on_q;
  assign State1236   = state_q[0];
  assign State5478   = state_q[1];
  assign FaultSticky = fault_q;

endmodule

// File: tb/tb_link_power_sequencer.sv
// tb/tb_link_power_sequencer.sv - Directed/randomized self-checking bench for link_power_sequencer.
module tb_link_power_sequencer;

  localparam int DET  = 12;
  localparam int RAMP = 20;
  localparam int COOL = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] Enable;
  logic       ProbeStart;
  logic       ProbeSel;
  logic       ProbeDone;
  logic       ProbeGood;
  logic [1:0] PairOk;
  logic [1:0] Overload;
  logic [1:0] PowerOn;
  logic [2:0] State1236;
  logic [2:0] State5478;
  logic [1:0] FaultSticky;
  logic       FaultClear;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic fav      = 1'b0;
  logic mon_busy = 1'b0;
  int   mon_left = 0;

  always #5 clk = ~clk;

  link_power_sequencer #(
    .DETECT_CYCLES(DET), .RAMP_CYCLES(RAMP), .COOLDOWN_CYCLES(COOL), .CNT_W(16)
  ) dut (
    .Clock100Mhz(clk), .ResetN(rst_n), .Enable(Enable),
    .ProbeStart(ProbeStart), .ProbeSel(ProbeSel), .ProbeDone(ProbeDone),
    .ProbeGood(ProbeGood), .PairOk(PairOk), .Overload(Overload),
    .PowerOn(PowerOn), .State1236(State1236), .State5478(State5478),
    .FaultSticky(FaultSticky), .FaultClear(FaultClear)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Round-robin reference: favour whoever was not granted last.
  task automatic expect_grant(input logic [1:0] req, output logic g);
    g   = (req == 2'b11) ? fav : req[1];
    fav = ~g;
  endtask

  function automatic logic [2:0] st_of(input logic g);
    return g ? State5478 : State1236;
  endfunction

  task automatic pulse_done(input logic good);
    ProbeDone = 1'b1;
    ProbeGood = good;
    step();
    ProbeDone = 1'b0;
    ProbeGood = 1'b0;
  endtask

  // Probe occupancy model: busy from ProbeStart for DET cycles or until ProbeDone.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
    end else begin
      if (mon_busy) chk("start_overlap", ProbeStart, 0);
      if (ProbeStart) begin
        mon_busy = 1'b1;
        mon_left = DET;
      end
      if (mon_busy) begin
        mon_left--;
        if (ProbeDone || mon_left == 0) mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic g, g2;
    int   d;
    Enable = 2'b00; ProbeDone = 1'b0; ProbeGood = 1'b0; PairOk = 2'b11;
    Overload = 2'b00; FaultClear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_power", PowerOn, 0);
    chk("rst_start", ProbeStart, 0);
    chk("rst_sel", ProbeSel, 0);
    chk("rst_fault", FaultSticky, 0);
    chk("rst_s1236", State1236, 0);
    chk("rst_s5478", State5478, 0);
    rst_n = 1'b1;
    step();

    Enable = 2'b01;
    step();
    chk("en_wait", State1236, 1);
    step();
    expect_grant(2'b01, g);
    chk("g1_start", ProbeStart, 1);
    chk("g1_sel", ProbeSel, 32'(g));
    chk("g1_probing", State1236, 2);
    repeat (3) step();
    chk("g1_pre_power", PowerOn, 0);
    pulse_done(1'b1);
    chk("g1_ramp", State1236, 3);
    chk("g1_power", PowerOn, 2'b01);
    repeat (RAMP - 1) step();
    chk("g1_ramp_hold", State1236, 3);
    step();
    chk("g1_on", State1236, 4);

    PairOk = 2'b10;
    step();
    chk("glitch_state", State1236, 4);
    PairOk = 2'b11;
    step();
    chk("glitch_recover", State1236, 4);
    PairOk = 2'b10;
    step();
    chk("pair_low1", State1236, 4);
    step();
    chk("pair_low2_power", PowerOn, 0);
    chk("pair_low2_state", State1236, 5);
    chk("pair_low2_fault", FaultSticky, 2'b01);
    PairOk = 2'b11;
    Enable = 2'b00;
    repeat (COOL - 1) step();
    chk("cool_hold", State1236, 5);
    step();
    chk("cool_idle", State1236, 0);
    FaultClear = 1'b1;
    step();
    FaultClear = 1'b0;
    chk("clear1", FaultSticky, 0);

    Enable = 2'b01;
    repeat (2) step();
    expect_grant(2'b01, g);
    chk("bad_start", ProbeStart, 1);
    chk("bad_sel", ProbeSel, 32'(g));
    d = $urandom_range(0, 4);
    repeat (d) step();
    pulse_done(1'b0);
    chk("bad_rewait", State1236, 1);
    step();
    expect_grant(2'b01, g);
    chk("bad_restart", ProbeStart, 1);
    chk("bad_reprobe", State1236, 2);
    chk("bad_nofault", FaultSticky, 0);
    repeat (DET - 1) step();
    chk("to_hold", State1236, 2);
    step();
    chk("to_cool", State1236, 5);
    chk("to_fault", FaultSticky, 2'b01);
    chk("to_power", PowerOn, 0);
    Enable = 2'b00;
    repeat (COOL - 1) step();
    chk("to_cool_hold", State1236, 5);
    step();
    chk("to_idle", State1236, 0);
    FaultClear = 1'b1;
    step();
    FaultClear = 1'b0;
    chk("clear2", FaultSticky, 0);

    rst_n = 1'b0;
    fav   = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    Enable = 2'b11;
    step();
    chk("c_wait0", State1236, 1);
    chk("c_wait1", State5478, 1);
    step();
    expect_grant(2'b11, g);
    chk("c1_start", ProbeStart, 1);
    chk("c1_sel", ProbeSel, 32'(g));
    d = $urandom_range(0, 4);
    repeat (d) step();
    pulse_done(1'b1);
    chk("c1_ramp", st_of(g), 3);
    step();
    expect_grant(g ? 2'b01 : 2'b10, g2);
    chk("c2_start", ProbeStart, 1);
    chk("c2_sel", ProbeSel, 32'(g2));
    d = $urandom_range(0, 4);
    repeat (d) step();
    pulse_done(1'b1);
    chk("c2_ramp", st_of(g2), 3);
    Enable = 2'b00;
    step();
    chk("c_off_power", PowerOn, 0);
    chk("c_off_state", State5478, 0);

    Enable = 2'b01;
    repeat (2) step();
    expect_grant(2'b01, g);
    chk("ab_start", ProbeStart, 1);
    Enable = 2'b00;
    step();
    chk("ab_idle", State1236, 0);
    Enable = 2'b11;
    repeat (3) step();
    chk("ab_blocked", ProbeStart, 0);
    chk("ab_wait1", State5478, 1);
    pulse_done(1'b1);
    chk("ab_noramp", State1236, 1);
    chk("ab_nopower", PowerOn, 0);
    step();
    expect_grant(2'b11, g);
    chk("ab_g1_start", ProbeStart, 1);
    chk("ab_g1_sel", ProbeSel, 32'(g));
    d = $urandom_range(0, 4);
    repeat (d) step();
    pulse_done(1'b1);
    chk("ab_g1_ramp", st_of(g), 3);
    step();
    expect_grant(g ? 2'b01 : 2'b10, g2);
    chk("ab_g2_start", ProbeStart, 1);
    chk("ab_g2_sel", ProbeSel, 32'(g2));
    d = $urandom_range(0, 4);
    repeat (d) step();
    pulse_done(1'b1);
    chk("ab_g2_ramp", st_of(g2), 3);
    repeat (RAMP) step();
    chk("both_on0", State1236, 4);
    chk("both_on1", State5478, 4);
    chk("both_power", PowerOn, 2'b11);

    Overload   = 2'b10;
    FaultClear = 1'b1;
    step();
    Overload   = 2'b00;
    FaultClear = 1'b0;
    chk("ovl_power", PowerOn, 2'b01);
    chk("ovl_state", State5478, 5);
    chk("ovl_fault_wins", FaultSticky, 2'b10);

    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_power", PowerOn, 0);
    chk("arst_start", ProbeStart, 0);
    chk("arst_sel", ProbeSel, 0);
    chk("arst_fault", FaultSticky, 0);
    chk("arst_s1236", State1236, 0);
    chk("arst_s5478", State5478, 0);
    Enable = 2'b00;
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
